sram_march_bist: RTL and testbench
==================================

Name: sram_march_bist

Overview:
- Built-in self-test engine that sits directly upstream of the 128x32 synchronous SRAM and drives its Data_in/Addr/Rw/En.
- Runs a March C- sequence over all 128 words and checks every read against the expected background.
- Reports pass/fail, the first failing address, element and data, and an error count.
- The SRAM data port is muxed to functional logic when Busy=0; that mux sits outside this block.

Parameters:
PATTERN, 32'h00000000, background written as "0"; "1" is ~PATTERN
STOP_ON_FAIL, 1, 1 = abort the run at the first mismatch; 0 = run to completion and count all mismatches

Ports:
Clk  in  1  clock
Rst  in  1  reset
Start  in  1  one-cycle request to begin a test; ignored while Busy=1
Busy  out  1  test in progress
Done  out  1  test finished; held until next accepted Start or Rst
Pass  out  1  valid when Done=1; 1 = zero mismatches
Err_count  out  8  mismatch count, saturates at 255
Fail_addr  out  7  address of first mismatch
Fail_elem  out  3  march element (0-5) of first mismatch
Fail_data  out  32  data read at first mismatch
Mem_data_in  out  32  to SRAM Data_in
Mem_addr  out  7  to SRAM Addr
Mem_rw  out  1  to SRAM Rw (1 = write, 0 = read)
Mem_en  out  1  to SRAM En
Mem_data_out  in  32  from SRAM Data_out

Behaviour:
- Reset is Rst, synchronous, active-high; clock is Clk.
- Rst clears every output to 0 and sets state IDLE. This applies mid-run too: the next cycle shows Mem_en=0 and Busy=0, the read pipeline is flushed, and no compare occurs.
- SRAM contract:
  - The SRAM samples Mem_* on the rising edge.
  - Read data appears on Mem_data_out in the cycle following the issuing cycle, and is 0 otherwise.
  - A read followed by a write to the same address returns the pre-write value.
- All Mem_* outputs are registered. Mem_en=0, Mem_rw=0, Mem_addr=0, Mem_data_in=0 whenever no op is issued.
- March elements, with ^ = address 0 to 127 and v = address 127 to 0:
  - E0 ^(w0)
  - E1 ^(r0,w1)
  - E2 ^(r1,w0)
  - E3 v(r0,w1)
  - E4 v(r1,w0)
  - E5 ^(r0)
- Within two-op elements, the read and write to one address occupy consecutive cycles; the next address follows immediately.
- Total issued ops: 128 + 4*256 + 128 = 1280, one per cycle, with no bubbles.
- States:
  - IDLE: Start=1 moves to RUN. On acceptance, clear Done, Pass, Err_count and the Fail_* outputs.
  - RUN: issue one op per cycle from the element, address and op-phase counters. After the last E5 read (address 127), go to DRAIN.
  - DRAIN: one cycle for the final compare, then go to DONE.
  - DONE: Done=1; Pass=(Err_count==0). Busy=0. Start=1 moves to RUN, clearing results as in IDLE.
- Busy=1 in RUN and DRAIN.
- Timing: with Start sampled at edge t, the first op is presented in cycle t+1 and Done=1 from cycle t+1282.
- Compare pipeline:
  - Each issued read stores its expected value, address and element in a 1-deep register.
  - In the next cycle, Mem_data_out is compared against the stored expected value.
  - Compares overlap with the following issue.
- On a mismatch:
  - Err_count increments, saturating at 255.
  - Fail_* are captured only if this is the first mismatch of the run.
  - If STOP_ON_FAIL=1, go to DONE in the next cycle with Pass=0. Any op issued in the same cycle as the mismatch completes but is not compared.
- Start asserted during RUN or DRAIN is ignored.
- Address counter:
  - Ascending elements wrap 127 to 0 at the element boundary.
  - Descending elements start at 127 and end at 0, then load the start address of the next element.
- Err_count is 8-bit. A fully broken array with STOP_ON_FAIL=0 yields 640 read mismatches, reported as 255.

Test Plan:
- Ideal SRAM model, PATTERN=0, STOP_ON_FAIL=1: pulse Start -> 1280 Mem_en cycles; Done rises 1282 cycles after Start; Pass=1; Err_count=0. Check that ops to address 126 follow address 127 in E3.
- Bit 5 of word 0x23 stuck-at-1, STOP_ON_FAIL=1 -> Fail_elem=1, Fail_addr=0x23, Fail_data=32'h00000020, Err_count=1, Pass=0. Done asserts 2 cycles after the failing read issues.
- Same fault with STOP_ON_FAIL=0 -> full run; mismatches in E1, E3 and E5 give Err_count=3; Fail_* hold the E1 capture; Pass=0.
- PATTERN=32'hA5A5A5A5, ideal SRAM -> E0 writes 32'hA5A5A5A5; E1 writes 32'h5A5A5A5A; Pass=1.
- Start pulsed at cycle 300 of a run -> no restart; Done timing unchanged.
- Rst asserted at cycle 500 of a run -> next cycle Busy=0, Mem_en=0, Done=0, Err_count=0. A new Start then runs a full test to Pass=1.

Source files
------------

// File: rtl/sram_march_bist.sv
// rtl/sram_march_bist.sv - March C- built-in self-test engine for a 128x32 synchronous SRAM
//
// Purpose: drives the SRAM port directly while Busy=1, runs a March C- sequence
// over all 128 words and checks every read against the expected background.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   Start               one-cycle test request (ignored while Busy=1)
//   Busy, Done, Pass    run status; Pass valid while Done=1
//   Err_count           mismatch count, saturating at 255
//   Fail_addr/elem/data first mismatch capture
//   Mem_data_in/addr/rw/en  registered SRAM controls (rw: 1 = write)
//   Mem_data_out        SRAM read data, valid the cycle after a read issues

module sram_march_bist #(
  parameter logic [31:0] PATTERN      = 32'h00000000,
  parameter bit          STOP_ON_FAIL = 1'b1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [7:0]  Err_count,
  output logic [6:0]  Fail_addr,
  output logic [2:0]  Fail_elem,
  output logic [31:0] Fail_data,
  output logic [31:0] Mem_data_in,
  output logic [6:0]  Mem_addr,
  output logic        Mem_rw,
  output logic        Mem_en,
  input  logic [31:0] Mem_data_out
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  elem_q, elem_d;
  logic [6:0]  addr_q, addr_d;
  logic        phase_q, phase_d;

  // Issue stage: the registered SRAM controls plus the tags of the op in flight.
  logic        mem_en_q, mem_en_d;
  logic        mem_rw_q, mem_rw_d;
  logic [6:0]  mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] op_exp_q, op_exp_d;
  logic [2:0]  op_elem_q, op_elem_d;

  // Compare stage: lines up with the cycle the SRAM returns read data.
  logic        cmp_valid_q, cmp_valid_d;
  logic [31:0] cmp_exp_q, cmp_exp_d;
  logic [6:0]  cmp_addr_q, cmp_addr_d;
  logic [2:0]  cmp_elem_q, cmp_elem_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [7:0]  err_q, err_d;
  logic [6:0]  fail_addr_q, fail_addr_d;
  logic [2:0]  fail_elem_q, fail_elem_d;
  logic [31:0] fail_data_q, fail_data_d;

  logic is_desc, op_is_read, rd_inv, wr_inv, last_addr, mismatch, abort;

  always_comb begin
    // Element decode: E3/E4 descend; E0 is write-only, E5 read-only.
    is_desc    = (elem_q == 3'd3) || (elem_q == 3'd4);
    op_is_read = (elem_q == 3'd5) || ((elem_q != 3'd0) && !phase_q);
    rd_inv     = (elem_q == 3'd2) || (elem_q == 3'd4);
    wr_inv     = (elem_q == 3'd1) || (elem_q == 3'd3);
    last_addr  = is_desc ? (addr_q == 7'd0) : (addr_q == 7'd127);
    mismatch   = cmp_valid_q && (Mem_data_out != cmp_exp_q);
    abort      = mismatch && STOP_ON_FAIL;
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_addr_d  = 7'd0;
    mem_din_d   = 32'd0;
    op_exp_d    = 32'd0;
    op_elem_d   = 3'd0;
    cmp_valid_d = mem_en_q && !mem_rw_q && !abort;
    cmp_exp_d   = op_exp_q;
    cmp_addr_d  = mem_addr_q;
    cmp_elem_d  = op_elem_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    err_d       = err_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    fail_data_d = fail_data_q;

    if (mismatch) begin
      err_d = (err_q == 8'd255) ? err_q : err_q + 8'd1;
      if (err_q == 8'd0) begin
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
        fail_data_d = Mem_data_out;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d     = S_RUN;
          elem_d      = 3'd0;
          addr_d      = 7'd0;
          phase_d     = 1'b0;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          err_d       = 8'd0;
          fail_addr_d = 7'd0;
          fail_elem_d = 3'd0;
          fail_data_d = 32'd0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = 1'b0;
        end else begin
          mem_en_d   = 1'b1;
          mem_rw_d   = !op_is_read;
          mem_addr_d = addr_q;
          op_elem_d  = elem_q;
          if (op_is_read) begin
            op_exp_d = rd_inv ? ~PATTERN : PATTERN;
          end else begin
            mem_din_d = wr_inv ? ~PATTERN : PATTERN;
          end
          // Read phase of a two-op element: write the same address next cycle.
          if (op_is_read && (elem_q != 3'd5)) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (last_addr) begin
              if (elem_q == 3'd5) begin
                state_d = S_DRAIN;
              end else begin
                elem_d = elem_q + 3'd1;
                // E3 and E4 start from the top of the array.
                addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? 7'd127 : 7'd0;
              end
            end else begin
              addr_d = is_desc ? addr_q - 7'd1 : addr_q + 7'd1;
            end
          end
        end
      end
      S_DRAIN: begin
        // First DRAIN cycle still has the last read in the issue stage; leave
        // once it has moved into the compare stage and is being checked.
        if (abort || !mem_en_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == 8'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      elem_q      <= 3'd0;
      addr_q      <= 7'd0;
      phase_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= 7'd0;
      mem_din_q   <= 32'd0;
      op_exp_q    <= 32'd0;
      op_elem_q   <= 3'd0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 32'd0;
      cmp_addr_q  <= 7'd0;
      cmp_elem_q  <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 8'd0;
      fail_addr_q <= 7'd0;
      fail_elem_q <= 3'd0;
      fail_data_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      op_exp_q    <= op_exp_d;
      op_elem_q   <= op_elem_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign Busy        = busy_q;
  assign Done        = done_q;
  assign Pass        = pass_q;
  assign Err_count   = err_q;
  assign Fail_addr   = fail_addr_q;
  assign Fail_elem   = fail_elem_q;
  assign Fail_data   = fail_data_q;
  assign Mem_en      = mem_en_q;
  assign Mem_rw      = mem_rw_q;
  assign Mem_addr    = mem_addr_q;
  assign Mem_data_in = mem_din_q;

endmodule

// File: tb/tb_sram_march_bist.sv
// tb/tb_sram_march_bist.sv - self-checking bench for sram_march_bist
module tb_sram_march_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fault = 1'b0;
  logic        start [3];
  logic        busy [3];
  logic        done [3];
  logic        pass [3];
  logic [7:0]  errc [3];
  logic [6:0]  faddr [3];
  logic [2:0]  felem [3];
  logic [31:0] fdata [3];
  logic [31:0] m_din [3];
  logic [6:0]  m_addr [3];
  logic        m_rw [3];
  logic        m_en [3];
  logic [31:0] m_dout [3];

  always #5 clk = ~clk;

  // Instance 0: PATTERN=0, STOP=1; 1: PATTERN=0, STOP=0; 2: PATTERN=A5A5A5A5, STOP=1
  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam logic [31:0] PAT  = (g == 2) ? 32'hA5A5A5A5 : 32'h0;
    localparam bit          STOP = (g == 1) ? 1'b0 : 1'b1;
    logic [31:0] mem [128];
    logic [31:0] dout;

    sram_march_bist #(.PATTERN(PAT), .STOP_ON_FAIL(STOP)) u_dut (
      .Clk(clk), .Rst(rst), .Start(start[g]),
      .Busy(busy[g]), .Done(done[g]), .Pass(pass[g]), .Err_count(errc[g]),
      .Fail_addr(faddr[g]), .Fail_elem(felem[g]), .Fail_data(fdata[g]),
      .Mem_data_in(m_din[g]), .Mem_addr(m_addr[g]), .Mem_rw(m_rw[g]),
      .Mem_en(m_en[g]), .Mem_data_out(m_dout[g])
    );

    // Ideal synchronous SRAM with an optional bit-5 stuck-at-1 on word 0x23.
    always @(posedge clk) begin
      if (m_en[g] && m_rw[g]) mem[m_addr[g]] <= m_din[g];
      if (m_en[g] && !m_rw[g])
        dout <= mem[m_addr[g]] | ((fault && m_addr[g] == 7'h23) ? 32'h20 : 32'h0);
      else
        dout <= 32'h0;
    end
    assign m_dout[g] = dout;
  end

  int sel = 0;
  logic        o_busy, o_done, o_pass, o_en, o_rw;
  logic [7:0]  o_err;
  logic [6:0]  o_faddr, o_addr;
  logic [2:0]  o_felem;
  logic [31:0] o_fdata, o_din;

  always_comb begin
    o_busy  = busy[sel];
    o_done  = done[sel];
    o_pass  = pass[sel];
    o_err   = errc[sel];
    o_faddr = faddr[sel];
    o_felem = felem[sel];
    o_fdata = fdata[sel];
    o_en    = m_en[sel];
    o_rw    = m_rw[sel];
    o_addr  = m_addr[sel];
    o_din   = m_din[sel];
  end

  typedef struct {
    logic        rw;
    logic [6:0]  addr;
    logic [31:0] data;
  } op_t;

  typedef struct {
    int          done_k;
    int          nops;
    logic        pass;
    logic [7:0]  err;
    logic [6:0]  faddr;
    logic [2:0]  felem;
    logic [31:0] fdata;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  int   n_asrt = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Builds the expected op stream and run result from a behavioural march
  // over a model array, then runs one test and checks it against them.
  task automatic run_test(input int inst, input logic [31:0] pat, input bit stop,
                          input bit flt, input int restart_at);
    logic [31:0] mm [128];
    logic [6:0]  a;
    logic [31:0] ev, rv, wv;
    int          n;
    bit          stopped, got_done;
    int          nops;
    res_t        r, er;
    op_t         o, eo;

    for (int i = 0; i < 128; i++) mm[i] = 32'h0;
    n = 0; stopped = 0;
    r.err = 8'd0; r.faddr = 7'd0; r.felem = 3'd0; r.fdata = 32'd0;
    r.done_k = 1282; r.nops = 1280;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < 128; i++) begin
        a = (e == 3 || e == 4) ? 7'(127 - i) : 7'(i);
        if (e != 0) begin
          ev = (e == 2 || e == 4) ? ~pat : pat;
          o.rw = 1'b0; o.addr = a; o.data = 32'h0;
          op_q.push_back(o);
          rv = mm[a] | ((flt && a == 7'h23) ? 32'h20 : 32'h0);
          if (!stopped && rv != ev) begin
            if (r.err == 8'd0) begin
              r.faddr = a; r.felem = 3'(e); r.fdata = rv;
            end
            if (r.err != 8'd255) r.err = r.err + 8'd1;
            if (stop) begin
              stopped  = 1;
              r.done_k = n + 3;
              r.nops   = (n + 2 > 1280) ? 1280 : n + 2;
            end
          end
          n++;
        end
        if (e != 5) begin
          wv = (e == 1 || e == 3) ? ~pat : pat;
          o.rw = 1'b1; o.addr = a; o.data = wv;
          op_q.push_back(o);
          mm[a] = wv;
          n++;
        end
      end
    end
    r.pass = (r.err == 8'd0);
    res_q.push_back(r);

    sel = inst;
    @(negedge clk); start[inst] = 1'b1;
    @(negedge clk); start[inst] = 1'b0;
    chk("busy_after_start", 64'(o_busy), 64'd1);
    got_done = 0; nops = 0;
    for (int k = 1; k <= 1400 && !got_done; k++) begin
      @(negedge clk);
      start[inst] = (k == restart_at);
      if (o_en) begin
        nops++;
        if (op_q.size() == 0) begin
          chk("op_unexpected", 64'(o_en), 64'd0);
        end else begin
          eo = op_q.pop_front();
          chk("op_rw", 64'(o_rw), 64'(eo.rw));
          chk("op_addr", 64'(o_addr), 64'(eo.addr));
          chk("op_data", 64'(o_din), 64'(eo.data));
        end
      end
      if (o_done) begin
        got_done = 1;
        er = res_q.pop_front();
        chk("done_cycle", 64'(k), 64'(er.done_k));
        chk("op_count", 64'(nops), 64'(er.nops));
        chk("pass", 64'(o_pass), 64'(er.pass));
        chk("err_count", 64'(o_err), 64'(er.err));
        chk("fail_addr", 64'(o_faddr), 64'(er.faddr));
        chk("fail_elem", 64'(o_felem), 64'(er.felem));
        chk("fail_data", 64'(o_fdata), 64'(er.fdata));
        chk("busy_at_done", 64'(o_busy), 64'd0);
      end
    end
    start[inst] = 1'b0;
    if (!got_done) begin
      chk("done_timeout", 64'(got_done), 64'd1);
      res_q.delete();
    end
    op_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      chk("rst_busy", 64'(o_busy), 64'd0);
      chk("rst_done", 64'(o_done), 64'd0);
      chk("rst_en", 64'(o_en), 64'd0);
      chk("rst_err", 64'(o_err), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_test(0, 32'h0, 1'b1, 1'b0, 0);
    fault = 1'b1;
    run_test(0, 32'h0, 1'b1, 1'b1, 0);
    run_test(1, 32'h0, 1'b0, 1'b1, 0);
    fault = 1'b0;
    run_test(2, 32'hA5A5A5A5, 1'b1, 1'b0, 0);
    run_test(0, 32'h0, 1'b1, 1'b0, 300);

    // Reset in mid-run after one mismatch has been counted.
    fault = 1'b1;
    sel = 1;
    @(negedge clk); start[1] = 1'b1;
    @(negedge clk); start[1] = 1'b0;
    repeat (500) @(negedge clk);
    chk("midrun_err", 64'(o_err), 64'd1);
    chk("midrun_busy", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", 64'(o_busy), 64'd0);
    chk("rst_mid_en", 64'(o_en), 64'd0);
    chk("rst_mid_done", 64'(o_done), 64'd0);
    chk("rst_mid_err", 64'(o_err), 64'd0);
    rst = 1'b0;
    fault = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 64'(o_err), 64'd0);
    run_test(1, 32'h0, 1'b0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
